// File: rtl/memory_ice40_spram_banked.sv
// Banked 32-bit main RAM on iCE40 SPRAM pairs: valid/ready requests, registered
// read response, and per-bank automatic SLEEP with a timed wake-up.

module memory_ice40_spram_banked_half (
  input  logic        i_clk,
  input  logic [13:0] i_address,
  input  logic [15:0] i_datain,
  input  logic [3:0]  i_maskwren,
  input  logic        i_wren,
  input  logic        i_chipselect,
  input  logic        i_standby,
  input  logic        i_sleep,
  input  logic        i_poweroff,
  output logic [15:0] o_dataout
);
  // Behavioural stand-in for one SB_SPRAM256KA (16K x 16, nibble write mask).
  logic [15:0] r_mem [16384];
  logic [15:0] r_dout;
  logic        w_en;

  assign w_en = i_chipselect && i_poweroff && !i_sleep && !i_standby;

  always_ff @(posedge i_clk) begin
    if (w_en) begin
      if (i_wren) begin
        if (i_maskwren[0]) r_mem[i_address][3:0]   <= i_datain[3:0];
        if (i_maskwren[1]) r_mem[i_address][7:4]   <= i_datain[7:4];
        if (i_maskwren[2]) r_mem[i_address][11:8]  <= i_datain[11:8];
        if (i_maskwren[3]) r_mem[i_address][15:12] <= i_datain[15:12];
      end else begin
        r_dout <= r_mem[i_address];
      end
    end
  end

  assign o_dataout = (i_poweroff && !i_sleep) ? r_dout : 16'h0000;
endmodule

module memory_ice40_spram_banked #(
  parameter  int BANKS       = 2,
  parameter  int IDLE_CYCLES = 64,
  parameter  int WAKE_CYCLES = 3,
  localparam int ADDR_W      = 14 + $clog2(BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [3:0]        req_wmask,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [BANKS-1:0]  bank_asleep
);
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int NB = 1 << BW;
  localparam int CW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {AWAKE, SLEEP, WAKING} bank_state_t;

  logic [BW-1:0] w_bank;
  logic [NB-1:0] w_awake;
  logic [31:0]   w_dout [NB];
  logic          w_accept;
  logic          w_powerOn;
  logic          r_rspValid;
  logic [BW-1:0] r_rspBank;
  logic [31:0]   r_rdataHold;

  generate
    if (BANKS > 1) begin : g_bankSel
      assign w_bank = req_addr[ADDR_W-1:14];
    end else begin : g_oneBank
      assign w_bank = '0;
    end
  endgenerate

  assign req_ready = !rst && w_awake[w_bank];
  assign w_accept  = req_valid && req_ready;
  // POWEROFF is active-low on the primitive: memory is unpowered while in reset.
  assign w_powerOn = !rst;

  generate
    for (genvar i = 0; i < NB; i++) begin : g_bank
      if (i < BANKS) begin : g_real
        bank_state_t   r_state, w_stateNext;
        logic [CW-1:0] r_idle, w_idleNext;
        logic [3:0]    r_wake, w_wakeNext;
        logic          w_hit, w_sel;

        assign w_hit = req_valid && (w_bank == BW'(i));
        assign w_sel = w_accept && (w_bank == BW'(i));

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_state <= AWAKE;
            r_idle  <= '0;
            r_wake  <= '0;
          end else begin
            r_state <= w_stateNext;
            r_idle  <= w_idleNext;
            r_wake  <= w_wakeNext;
          end
        end

        // An access in the cycle the idle limit would be reached keeps the bank awake.
        always_comb begin
          w_stateNext = r_state;
          w_idleNext  = r_idle;
          w_wakeNext  = r_wake;
          case (r_state)
            AWAKE: begin
              if (w_sel) begin
                w_idleNext = '0;
              end else begin
                if (r_idle != {CW{1'b1}}) w_idleNext = r_idle + 1'b1;
                if (IDLE_CYCLES != 0 && w_idleNext == CW'(IDLE_CYCLES)) begin
                  w_stateNext = SLEEP;
                  w_idleNext  = '0;
                end
              end
            end
            SLEEP: begin
              if (w_hit) begin
                w_stateNext = WAKING;
                w_wakeNext  = 4'(WAKE_CYCLES);
              end
            end
            WAKING: begin
              if (r_wake <= 4'd1) begin
                w_stateNext = AWAKE;
                w_wakeNext  = '0;
              end else begin
                w_wakeNext = r_wake - 1'b1;
              end
            end
            default: w_stateNext = AWAKE;
          endcase
        end

        assign w_awake[i]     = (r_state == AWAKE);
        assign bank_asleep[i] = (r_state != AWAKE);

        memory_ice40_spram_banked_half u_upper (
          .i_clk        (clk),
          .i_address    (req_addr[13:0]),
          .i_datain     (req_wdata[31:16]),
          .i_maskwren   ({req_wmask[3], req_wmask[3], req_wmask[2], req_wmask[2]}),
          .i_wren       (req_wen),
          .i_chipselect (w_sel),
          .i_standby    (1'b0),
          .i_sleep      (r_state == SLEEP),
          .i_poweroff   (w_powerOn),
          .o_dataout    (w_dout[i][31:16])
        );

        memory_ice40_spram_banked_half u_lower (
          .i_clk        (clk),
          .i_address    (req_addr[13:0]),
          .i_datain     (req_wdata[15:0]),
          .i_maskwren   ({req_wmask[1], req_wmask[1], req_wmask[0], req_wmask[0]}),
          .i_wren       (req_wen),
          .i_chipselect (w_sel),
          .i_standby    (1'b0),
          .i_sleep      (r_state == SLEEP),
          .i_poweroff   (w_powerOn),
          .o_dataout    (w_dout[i][15:0])
        );
      end else begin : g_pad
        assign w_awake[i] = 1'b0;
        assign w_dout[i]  = 32'h0;
      end
    end
  endgenerate

  // Read response pipeline; the hold register keeps rsp_rdata stable between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspValid  <= 1'b0;
      r_rspBank   <= '0;
      r_rdataHold <= 32'h0;
    end else begin
      r_rspValid <= w_accept && !req_wen;
      if (w_accept && !req_wen) r_rspBank <= w_bank;
      if (r_rspValid) r_rdataHold <= w_dout[r_rspBank];
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspValid ? w_dout[r_rspBank] : r_rdataHold;
endmodule

// File: tb/tb_memory_ice40_spram_banked.sv
// Directed bench for memory_ice40_spram_banked (BANKS=2, IDLE_CYCLES=8, WAKE_CYCLES=3).

module tb_memory_ice40_spram_banked;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [3:0]  req_wmask;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  bank_asleep;

  int checks = 0;
  int errors = 0;
  int waits;
  int b1Idle;

  memory_ice40_spram_banked #(
    .BANKS       (2),
    .IDLE_CYCLES (8),
    .WAKE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_wmask   (req_wmask),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .bank_asleep (bank_asleep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic applyStimulus(input logic wen, input logic [14:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, output int nWait);
    bit done;
    done      = 1'b0;
    nWait     = 0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = data;
    req_wmask = mask;
    while (!done && nWait < 20) begin
      #1;
      if (req_ready) done = 1'b1;
      else nWait++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_wen   = 1'b0;
    checkOutput("handshake accepted", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_wmask = 4'h0; req_addr = '0; req_wdata = '0;
    #3;
    req_valid = 1'b1;
    #1;
    checkOutput("reset req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset bank_asleep", {30'b0, bank_asleep}, 32'd0);
    req_valid = 1'b0;
    step();
    rst = 1'b0;

    applyStimulus(1'b1, 15'h0010, 32'hDEADBEEF, 4'hF, waits);
    checkOutput("first write wait", waits, 32'd0);
    applyStimulus(1'b0, 15'h0010, 32'h0, 4'h0, waits);
    checkOutput("read wait", waits, 32'd0);
    checkOutput("read rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("read rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    checkOutput("rsp_valid pulse ends", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rdata held", rsp_rdata, 32'hDEADBEEF);

    applyStimulus(1'b1, 15'h0020, 32'hAAAAAAAA, 4'hF, waits);
    applyStimulus(1'b1, 15'h0020, 32'h11223344, 4'b0101, waits);
    applyStimulus(1'b0, 15'h0020, 32'h0, 4'h0, waits);
    checkOutput("byte mask rdata", rsp_rdata, 32'hAA22AA44);

    applyStimulus(1'b1, 15'h0005, 32'h00000001, 4'hF, waits);
    applyStimulus(1'b1, 15'h4005, 32'h00000002, 4'hF, waits);
    checkOutput("access at idle limit wait", waits, 32'd0);
    checkOutput("access at idle limit awake", {30'b0, bank_asleep}, 32'd0);
    applyStimulus(1'b0, 15'h0005, 32'h0, 4'h0, waits);
    checkOutput("bank0 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("bank0 rdata", rsp_rdata, 32'h00000001);
    applyStimulus(1'b0, 15'h4005, 32'h0, 4'h0, waits);
    checkOutput("bank1 back-to-back wait", waits, 32'd0);
    checkOutput("bank1 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("bank1 rdata", rsp_rdata, 32'h00000002);

    b1Idle = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 15'h0030, 32'(k), 4'hF, waits);
      b1Idle++;
      checkOutput("periodic bank0 wait", waits, 32'd0);
      for (int j = 0; j < 3; j++) begin
        step();
        b1Idle++;
        checkOutput("bank0 stays awake", {31'b0, bank_asleep[0]}, 32'd0);
        checkOutput("bank1 sleep timing", {31'b0, bank_asleep[1]}, {31'b0, (b1Idle >= 8)});
      end
    end

    applyStimulus(1'b0, 15'h4005, 32'h0, 4'h0, waits);
    checkOutput("wake latency", waits, 32'd4);
    checkOutput("wake rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("wake rdata intact", rsp_rdata, 32'h00000002);
    checkOutput("bank1 awake after wake", {31'b0, bank_asleep[1]}, 32'd0);

    for (int j = 0; j < 8; j++) step();
    checkOutput("both banks asleep", {30'b0, bank_asleep}, 32'd3);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 15'h4005;
    step();
    step();
    checkOutput("mid-wake asleep", {31'b0, bank_asleep[1]}, 32'd1);
    checkOutput("mid-wake ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("reset mid-wake ready", {31'b0, req_ready}, 32'd0);
    checkOutput("reset mid-wake asleep", {30'b0, bank_asleep}, 32'd0);
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 15'h4005, 32'h0, 4'h0, waits);
    checkOutput("post-reset read wait", waits, 32'd0);
    checkOutput("post-reset rsp_valid", {31'b0, rsp_valid}, 32'd1);

    applyStimulus(1'b0, 15'h0010, 32'h0, 4'h0, waits);
    checkOutput("in-flight read rsp_valid", {31'b0, rsp_valid}, 32'd1);
    req_valid = 1'b1; req_addr = 15'h0010;
    rst = 1'b1;
    #1;
    checkOutput("reset mid-read rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset mid-read rdata", rsp_rdata, 32'h0);
    checkOutput("reset mid-read ready", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    step();
    checkOutput("no response after reset", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b1, 15'h0040, 32'h0BADF00D, 4'hF, waits);
    applyStimulus(1'b1, 15'h0040, 32'hFFFFFFFF, 4'h0, waits);
    applyStimulus(1'b0, 15'h0040, 32'h0, 4'h0, waits);
    checkOutput("zero mask write no change", rsp_rdata, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_ice40_spram_banked.md
Name: memory_ice40_spram_banked

Overview:
- 32-bit word memory built from BANKS pairs of iCE40 SB_SPRAM256KA primitives; each pair is 16K words (64 KiB).
- Adds a valid/ready request handshake, a registered read response, and per-bank automatic low-power SLEEP with a timed wake-up.
- Sits between the SoC bus interconnect and the SPRAM primitives as the main RAM.
- With BANKS=1 and IDLE_CYCLES=0 it behaves as a plain single-cycle SPRAM with a handshake.

Parameters:
- BANKS, 2, number of 16K-word banks (1, 2 or 4); each bank is two SPRAM primitives (upper and lower halfword).
- IDLE_CYCLES, 64, consecutive cycles a bank goes unaccessed before it enters SLEEP; 0 disables sleep.
- WAKE_CYCLES, 3, cycles spent in WAKING before a slept bank accepts requests (range 1..15).
- ADDR_W, 14+$clog2(BANKS), word-address width (derived, not overridden).

Ports:
- clk  in  1  system clock; every flop is rising-edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_wen  in  1  1 = write, 0 = read.
- req_wmask  in  4  byte write enables; bit n covers wdata[8n+7:8n].
- req_addr  in  ADDR_W  word address; the top $clog2(BANKS) bits select the bank, the low 14 bits are the SPRAM address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  read data valid, single-cycle pulse.
- rsp_rdata  out  32  read data, held stable until the next read response.
- bank_asleep  out  BANKS  per-bank status; 1 = bank is in SLEEP or WAKING.

Behaviour:
- Reset: async assert.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, bank_asleep=0.
  - Every bank FSM goes to AWAKE with its idle counter cleared.
  - POWEROFF pin is driven low (powered off) while rst=1, so contents are lost.
  - Deassert: synchronous release; first acceptance is possible on the first clk edge after rst falls.
- Per-bank FSM, states AWAKE, SLEEP, WAKING.
  - AWAKE: idle counter increments on each cycle with no accepted request to this bank and clears on an accepted request. When the counter reaches IDLE_CYCLES and IDLE_CYCLES!=0, the bank moves to SLEEP and its SLEEP pin is asserted.
  - SLEEP: a req_valid addressing this bank moves it to WAKING and loads the wake counter with WAKE_CYCLES.
  - WAKING: SLEEP pin is low; the counter decrements and the bank moves to AWAKE when it reaches 0.
  - The request is held by the master (valid/ready rule) and is accepted in the first AWAKE cycle.
- req_ready is combinational: !rst && (addressed bank is AWAKE).
  - A request to an AWAKE bank is accepted in the same cycle.
  - Wake latency from a sleeping bank: WAKE_CYCLES+1 cycles from req_valid to acceptance.
- Handshake: once req_valid=1 the master holds it, with address, data and mask unchanged, until accepted. The block does not need to tolerate violations of this rule.
- Read: acceptance drives CHIPSELECT high only on the addressed bank pair.
  - rsp_valid=1 and rsp_rdata=bank DATAOUT exactly one cycle later.
  - Back-to-back reads give one response per cycle.
  - The output mux uses the registered bank index.
- Write: MASKWREN per SPRAM = {wmask[3],wmask[3],wmask[2],wmask[2]} for the upper primitive and {wmask[1],wmask[1],wmask[0],wmask[0]} for the lower.
  - No response is generated.
  - wmask=0 is accepted and changes no data.
- Simultaneous events:
  - An accepted access in the same cycle the idle counter reaches IDLE_CYCLES: the access wins, the bank stays AWAKE and the counter clears.
  - Requests to other banks do not reset a bank's counter.
- Idle counter saturates and never wraps; width is $clog2(IDLE_CYCLES+1).
- STANDBY is tied low. Non-selected banks have CHIPSELECT=0.
- Reset mid-wake or mid-read: all state clears; no rsp_valid is produced for an in-flight read.

Test Plan:
- Write 0xDEADBEEF with wmask=4'hF to addr 0x0010, then read addr 0x0010 → req_ready=1 in both cycles; rsp_valid one cycle after the read; rsp_rdata=0xDEADBEEF.
- Byte masks: write 0x11223344 with wmask=4'b0101 over 0xAAAAAAAA, then read → 0xAA22AA44.
- BANKS=2, write 0x1 at 0x0005 and 0x2 at 0x4005, then read both back-to-back → two consecutive rsp_valid pulses carrying 0x1 then 0x2 (no aliasing between banks).
- IDLE_CYCLES=8, WAKE_CYCLES=3, leave bank 1 untouched for 8 cycles → bank_asleep[1]=1. A read to bank 1 sees req_ready=0 for 4 cycles and is accepted on the 5th; the data written before sleep is returned intact.
- Access bank 0 every 4th cycle with IDLE_CYCLES=8 → bank_asleep[0] stays 0 throughout; bank 1 sleeps after 8 cycles.
- Assert rst during WAKING and with a read in flight → req_ready=0 and rsp_valid=0 immediately; after release all bank_asleep=0 and a new read is accepted in its first cycle.
